mem_access_guard: RTL and testbench
===================================

// Module: mem_access_guard
// PURPOSE
//  Parametrised successor to the single-region secure-data monitor.
//  Watches each executed pc and each data-bus access against N_REGIONS protected data regions.
//  Each region has its own trusted-code (owner) range, a foreign-access policy and an optional
//  entry-point (atomicity) check. On any violation it raises the core reset request, holds it for
//  at least HOLD_CYCLES, and releases it only when pc reaches RESET_HANDLER. Sits beside the core
//  on the pc/data-address taps, like the other VRASED hw-mod monitors.
// PARAMETERS
//  ADDR_W        16                    address/pc width
//  N_REGIONS     2                     number of protected regions (1..8)
//  D_BASE        {16'h9000,16'h0400}   per-region data first addr, region i at [i*ADDR_W +: ADDR_W]
//  D_LAST        {16'h901E,16'h0FFF}   per-region data last addr (inclusive)
//  O_BASE        {16'hA000,16'hA000}   per-region owner-code first addr (also the only legal entry point)
//  O_LAST        {16'hDFFE,16'hDFFE}   per-region owner-code last addr (inclusive)
//  PERM          4'b01_00              2 bits/region: [0]=foreign read allowed, [1]=foreign write allowed
//  ENTRY_CHK     2'b01                 1 bit/region: enforce entry only at O_BASE
//  HOLD_CYCLES   4                     minimum reset-assert cycles (>=1)
//  RESET_HANDLER 16'hFFFE              pc value that permits release
// PORTS
//  clk          in   1               system clock
//  rst          in   1               async active-high reset
//  pc           in   ADDR_W          current instruction address
//  data_addr    in   ADDR_W          data-bus address
//  r_en         in   1               data read this cycle
//  w_en         in   1               data write this cycle
//  reset        out  1               reset request to core (registered)
//  viol_region  out  N_REGIONS       regions that caused the latest violation (sticky while KILL)
//  viol_type    out  3               {entry, write, read} cause of the latest violation
//  viol_count   out  8               saturating count of RUN->KILL events
// BEHAVIOUR
//  - rst asserted: state=RUN, reset=0, viol_region=0, viol_type=0, viol_count=0, hold_cnt=0, prev_vld=0.
//  - Per region i, combinational:
//    own_i = O_BASE_i<=pc<=O_LAST_i; hit_i = D_BASE_i<=data_addr<=D_LAST_i.
//    rd_v_i = !own_i & hit_i & r_en & !PERM_i[0]; wr_v_i = !own_i & hit_i & w_en & !PERM_i[1].
//    en_v_i = ENTRY_CHK_i & prev_vld & own_i & !prev_own_i & (pc!=O_BASE_i).
//    prev_own_i uses prev_pc; prev_pc/prev_vld load pc/1 every cycle after rst.
//  - viol = OR over all regions of (rd_v|wr_v|en_v). Overlapping regions are evaluated independently;
//    any one violating is enough. r_en&w_en together are checked for both.
//  - FSM, 2 states:
//    RUN:  viol -> KILL; hold_cnt<=HOLD_CYCLES-1; viol_region<=per-region OR mask; viol_type<=ORed causes;
//          viol_count<=min(count+1,255).
//    KILL: hold_cnt decrements to 0 and stops. Exit to RUN when hold_cnt==0 & pc==RESET_HANDLER & !viol.
//          A violation in KILL does not re-count, re-arm hold or change viol_* .
//  - reset: registered; 1 the cycle after the RUN->KILL edge, through all of KILL;
//    0 the cycle after the KILL->RUN edge. Latency 1 clk in both directions; minimum high time HOLD_CYCLES.
//  - viol_region/viol_type keep their values after return to RUN; they are overwritten only by the next violation.
//  - Release blocked if pc==RESET_HANDLER while hold_cnt>0 or while viol=1; stays in KILL.
//  - Comparisons are unsigned, inclusive, no wrap; D_LAST<D_BASE describes an empty region (never hits).
//  - rst mid-KILL: immediate return to the reset values above; prev_vld=0 suppresses the entry check on the first cycle.
// TESTING
//  1 pc=0xE000, data_addr=0x0500, r_en=1 -> reset=1 next clk; viol_region=2'b01; viol_type=3'b001; viol_count=1.
//  2 pc=0xE000, data_addr=0x9004, r_en=1 -> no violation (region1 foreign read allowed); same with w_en=1 -> reset=1, viol_type=3'b010, viol_region=2'b10.
//  3 pc 0xE000 -> 0xA010 (mid-entry) -> entry violation, viol_type=3'b100; pc 0xE000 -> 0xA000 -> no violation; pc 0xA010 -> 0xA012 -> no violation.
//  4 violation, then pc=0xFFFE on the 2nd KILL cycle -> reset stays 1; pc=0xFFFE after 4 reset-high cycles -> reset=0 next clk, viol_count still 1.
//  5 in KILL, pc=0xFFFE together with a region0 write -> stays KILL, viol_count unchanged; 300 violation episodes -> viol_count=255.
//  6 assert rst during KILL -> reset=0, viol_*=0 asynchronously; first cycle after rst, pc=0xA010 -> no entry violation.

Source files
------------

// File: rtl/mem_access_guard.sv
// -----------------------------------------------------------------------------
// mem_access_guard
//   Watches the executed pc and every data-bus access against N_REGIONS
//   protected data regions. Each region has an owner-code range (the only
//   code allowed to touch it freely), a foreign read/write policy and an
//   optional entry-point check: owner code may only be entered at O_BASE.
//   Any violation raises the core reset request. The request is held for at
//   least HOLD_CYCLES and is released only once pc reaches RESET_HANDLER
//   with no violation pending.
//
// Ports
//   clk          in   1          system clock
//   rst          in   1          asynchronous active-high reset
//   pc           in   ADDR_W     current instruction address
//   data_addr    in   ADDR_W     data-bus address
//   r_en         in   1          data read this cycle
//   w_en         in   1          data write this cycle
//   reset        out  1          registered reset request to the core
//   viol_region  out  N_REGIONS  regions involved in the latest violation
//   viol_type    out  3          {entry, write, read} cause of latest violation
//   viol_count   out  8          saturating count of RUN->KILL events
// -----------------------------------------------------------------------------
module mem_access_guard #(
  parameter int                              ADDR_W        = 16,
  parameter int                              N_REGIONS     = 2,
  parameter logic [N_REGIONS*ADDR_W-1:0]     D_BASE        = {16'h9000, 16'h0400},
  parameter logic [N_REGIONS*ADDR_W-1:0]     D_LAST        = {16'h901E, 16'h0FFF},
  parameter logic [N_REGIONS*ADDR_W-1:0]     O_BASE        = {16'hA000, 16'hA000},
  parameter logic [N_REGIONS*ADDR_W-1:0]     O_LAST        = {16'hDFFE, 16'hDFFE},
  parameter logic [2*N_REGIONS-1:0]          PERM          = 4'b01_00,
  parameter logic [N_REGIONS-1:0]            ENTRY_CHK     = 2'b01,
  parameter int                              HOLD_CYCLES   = 4,
  parameter logic [ADDR_W-1:0]               RESET_HANDLER = 16'hFFFE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic                 r_en,
  input  logic                 w_en,
  output logic                 reset,
  output logic [N_REGIONS-1:0] viol_region,
  output logic [2:0]           viol_type,
  output logic [7:0]           viol_count
);

  // The hold counter only ever holds values 0..HOLD_CYCLES-1.
  localparam int               HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  state_t                 r_state;
  logic [HC_W-1:0]        r_hold_cnt;
  logic                   r_reset;
  logic [N_REGIONS-1:0]   r_viol_region;
  logic [2:0]             r_viol_type;
  logic [7:0]             r_viol_count;
  logic [ADDR_W-1:0]      r_prev_pc;
  logic                   r_prev_vld;

  state_t                 w_state_next;
  logic [HC_W-1:0]        w_hold_next;
  logic                   w_reset_next;
  logic [N_REGIONS-1:0]   w_region_next;
  logic [2:0]             w_type_next;
  logic [7:0]             w_count_next;

  logic [N_REGIONS-1:0]   w_own;
  logic [N_REGIONS-1:0]   w_prev_own;
  logic [N_REGIONS-1:0]   w_hit;
  logic [N_REGIONS-1:0]   w_rd_v;
  logic [N_REGIONS-1:0]   w_wr_v;
  logic [N_REGIONS-1:0]   w_en_v;
  logic [N_REGIONS-1:0]   w_viol_mask;
  logic [2:0]             w_viol_cause;
  logic                   w_viol;

  // Per-region checks. Regions are independent, so overlapping regions can
  // each flag the same access. An empty region (D_LAST < D_BASE) never hits
  // because both inclusive bounds must hold at once.
  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
      assign w_own[gi]      = (pc >= O_BASE[gi*ADDR_W +: ADDR_W]) &&
                              (pc <= O_LAST[gi*ADDR_W +: ADDR_W]);
      assign w_prev_own[gi] = (r_prev_pc >= O_BASE[gi*ADDR_W +: ADDR_W]) &&
                              (r_prev_pc <= O_LAST[gi*ADDR_W +: ADDR_W]);
      assign w_hit[gi]      = (data_addr >= D_BASE[gi*ADDR_W +: ADDR_W]) &&
                              (data_addr <= D_LAST[gi*ADDR_W +: ADDR_W]);
      assign w_rd_v[gi]     = !w_own[gi] && w_hit[gi] && r_en && !PERM[2*gi];
      assign w_wr_v[gi]     = !w_own[gi] && w_hit[gi] && w_en && !PERM[2*gi+1];
      // Jumping into owner code anywhere but its base is an entry violation.
      // r_prev_vld keeps a stale prev_pc from tripping this right after rst.
      assign w_en_v[gi]     = ENTRY_CHK[gi] && r_prev_vld && w_own[gi] &&
                              !w_prev_own[gi] &&
                              (pc != O_BASE[gi*ADDR_W +: ADDR_W]);
      assign w_viol_mask[gi] = w_rd_v[gi] || w_wr_v[gi] || w_en_v[gi];
    end
  endgenerate

  assign w_viol       = |w_viol_mask;
  assign w_viol_cause = {|w_en_v, |w_wr_v, |w_rd_v};

  // Next-state and next-output logic.
  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = r_hold_cnt;
    w_region_next = r_viol_region;
    w_type_next   = r_viol_type;
    w_count_next  = r_viol_count;

    case (r_state)
      ST_RUN: begin
        if (w_viol) begin
          w_state_next  = ST_KILL;
          w_hold_next   = HOLD_INIT;
          w_region_next = w_viol_mask;
          w_type_next   = w_viol_cause;
          w_count_next  = (r_viol_count == 8'hFF) ? r_viol_count : r_viol_count + 8'd1;
        end
      end
      ST_KILL: begin
        // Further violations while killed are ignored: no re-arm, no re-count.
        if (r_hold_cnt != '0) begin
          w_hold_next = r_hold_cnt - 1'b1;
        end
        if ((r_hold_cnt == '0) && (pc == RESET_HANDLER) && !w_viol) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // Registering this gives exactly one clock of latency on both edges.
    w_reset_next = (w_state_next == ST_KILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_hold_cnt    <= '0;
      r_reset       <= 1'b0;
      r_viol_region <= '0;
      r_viol_type   <= '0;
      r_viol_count  <= '0;
      r_prev_pc     <= '0;
      r_prev_vld    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_hold_cnt    <= w_hold_next;
      r_reset       <= w_reset_next;
      r_viol_region <= w_region_next;
      r_viol_type   <= w_type_next;
      r_viol_count  <= w_count_next;
      r_prev_pc     <= pc;
      r_prev_vld    <= 1'b1;
    end
  end

  assign reset       = r_reset;
  assign viol_region = r_viol_region;
  assign viol_type   = r_viol_type;
  assign viol_count  = r_viol_count;

endmodule

// File: tb/tb_mem_access_guard.sv
module tb_mem_access_guard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'hE000;
  logic [15:0] data_addr = 16'h0000;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic        reset;
  logic [1:0]  viol_region;
  logic [2:0]  viol_type;
  logic [7:0]  viol_count;

  int checks = 0;
  int errors = 0;

  mem_access_guard dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .data_addr   (data_addr),
    .r_en        (r_en),
    .w_en        (w_en),
    .reset       (reset),
    .viol_region (viol_region),
    .viol_type   (viol_type),
    .viol_count  (viol_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        e_reset;
    logic [1:0]  e_region;
    logic [2:0]  e_type;
    logic [7:0]  e_count;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] pa;
    logic [15:0] pb;
    logic [15:0] addr;
    logic        r;
    logic        w;
    logic        e_reset;
    logic [1:0]  e_region;
    logic [2:0]  e_type;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      check({e.name, ".reset"},  {7'd0, reset},       {7'd0, e.e_reset});
      check({e.name, ".region"}, {6'd0, viol_region}, {6'd0, e.e_region});
      check({e.name, ".type"},   {5'd0, viol_type},   {5'd0, e.e_type});
      check({e.name, ".count"},  viol_count,          e.e_count);
      $display("txn %-14s pc=%h addr=%h r=%0b w=%0b -> reset=%0b region=%b type=%b count=%0d",
               e.name, pc, data_addr, r_en, w_en, reset, viol_region, viol_type, viol_count);
    end
  endtask

  // One clock: drive inputs, optionally queue the expected outputs, and
  // compare them 1 ns after the active edge.
  task automatic cyc(input logic [15:0] p, input logic [15:0] a, input logic r,
                     input logic w, input bit chk, input string nm,
                     input logic er, input logic [1:0] eg, input logic [2:0] et,
                     input logic [7:0] ec);
    exp_t e;
    pc = p; data_addr = a; r_en = r; w_en = w;
    if (chk) begin
      e.name = nm; e.e_reset = er; e.e_region = eg; e.e_type = et; e.e_count = ec;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (chk) compare_out();
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1; pc = 16'hE000; data_addr = 16'h0000; r_en = 1'b0; w_en = 1'b0;
    #1;
    if (chk) begin
      check("async_rst.reset",  {7'd0, reset},       8'd0);
      check("async_rst.region", {6'd0, viol_region}, 8'd0);
      check("async_rst.type",   {5'd0, viol_type},   8'd0);
      check("async_rst.count",  viol_count,          8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs.push_back('{"rd_r0",       16'hE000, 16'hE000, 16'h0500, 1'b1, 1'b0, 1'b1, 2'b01, 3'b001});
    vecs.push_back('{"rd_r1_ok",    16'hE000, 16'hE000, 16'h9004, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"wr_r1",       16'hE000, 16'hE000, 16'h9004, 1'b0, 1'b1, 1'b1, 2'b10, 3'b010});
    vecs.push_back('{"entry_mid",   16'hE000, 16'hA010, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b01, 3'b100});
    vecs.push_back('{"entry_base",  16'hE000, 16'hA000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"inside_own",  16'hA010, 16'hA012, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"owner_rd",    16'hA000, 16'hA010, 16'h0500, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"wr_r0_base",  16'hE000, 16'hE000, 16'h0400, 1'b0, 1'b1, 1'b1, 2'b01, 3'b010});
    vecs.push_back('{"rd_r0_last",  16'hE000, 16'hE000, 16'h0FFF, 1'b1, 1'b0, 1'b1, 2'b01, 3'b001});
    vecs.push_back('{"rd_past_r0",  16'hE000, 16'hE000, 16'h1000, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"wr_below_r0", 16'hE000, 16'hE000, 16'h03FF, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"wr_r1_last",  16'hE000, 16'hE000, 16'h901E, 1'b0, 1'b1, 1'b1, 2'b10, 3'b010});
    vecs.push_back('{"wr_past_r1",  16'hE000, 16'hE000, 16'h901F, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"own_last",    16'hDFFE, 16'hDFFE, 16'h0500, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000});
    vecs.push_back('{"past_own",    16'hE000, 16'hDFFF, 16'h0500, 1'b1, 1'b0, 1'b1, 2'b01, 3'b001});
    vecs.push_back('{"below_own",   16'hE000, 16'h9FFF, 16'h0800, 1'b0, 1'b1, 1'b1, 2'b01, 3'b010});
    vecs.push_back('{"rw_r0",       16'hE000, 16'hE000, 16'h0500, 1'b1, 1'b1, 1'b1, 2'b01, 3'b011});
    vecs.push_back('{"rw_r1",       16'hE000, 16'hE000, 16'h9004, 1'b1, 1'b1, 1'b1, 2'b10, 3'b010});

    // Reset state.
    #12;
    check("init.reset",  {7'd0, reset},       8'd0);
    check("init.region", {6'd0, viol_region}, 8'd0);
    check("init.type",   {5'd0, viol_type},   8'd0);
    check("init.count",  viol_count,          8'd0);
    do_reset(1'b0);

    // Table-driven single-violation vectors, each from a fresh reset.
    foreach (vecs[i]) begin
      do_reset(1'b0);
      cyc(vecs[i].pa, 16'h0000, 1'b0, 1'b0, 1'b0, "", 1'b0, 2'b00, 3'b000, 8'd0);
      cyc(vecs[i].pb, vecs[i].addr, vecs[i].r, vecs[i].w, 1'b1, vecs[i].name,
          vecs[i].e_reset, vecs[i].e_region, vecs[i].e_type,
          vecs[i].e_reset ? 8'd1 : 8'd0);
    end

    // Hold time and release at the reset handler.
    do_reset(1'b0);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    cyc(16'hE000, 16'h0500, 1, 0, 1, "hold.viol",  1, 2'b01, 3'b001, 8'd1);
    cyc(16'hE000, 16'h0000, 0, 0, 1, "hold.k1",    1, 2'b01, 3'b001, 8'd1);
    cyc(16'hFFFE, 16'h0000, 0, 0, 1, "hold.early", 1, 2'b01, 3'b001, 8'd1);
    cyc(16'hE000, 16'h0000, 0, 0, 1, "hold.k3",    1, 2'b01, 3'b001, 8'd1);
    cyc(16'hFFFE, 16'h0000, 0, 0, 1, "hold.rel",   0, 2'b01, 3'b001, 8'd1);
    cyc(16'hE000, 16'h0000, 0, 0, 1, "hold.run",   0, 2'b01, 3'b001, 8'd1);

    // Release blocked by a concurrent violation; then saturation.
    do_reset(1'b0);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    cyc(16'hE000, 16'h0500, 1, 0, 1, "blk.viol",   1, 2'b01, 3'b001, 8'd1);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    cyc(16'hFFFE, 16'h0500, 0, 1, 1, "blk.wr",     1, 2'b01, 3'b001, 8'd1);
    cyc(16'hFFFE, 16'h0000, 0, 0, 1, "blk.rel",    0, 2'b01, 3'b001, 8'd1);
    cnt = 1;
    for (int n = 0; n < 300; n++) begin
      cnt = (cnt == 255) ? 255 : cnt + 1;
      cyc(16'hE000, 16'h9010, 0, 1, (n == 100), "sat.mid", 1, 2'b10, 3'b010, 8'(cnt));
      cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
      cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
      cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
      cyc(16'hFFFE, 16'h0000, 0, 0, (n == 299), "sat.end", 0, 2'b10, 3'b010, 8'(cnt));
    end

    // Asynchronous reset in KILL, and entry check suppressed on first cycle.
    cyc(16'hE000, 16'h0500, 1, 0, 1, "rk.viol", 1, 2'b01, 3'b001, 8'd255);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    do_reset(1'b1);
    cyc(16'hA010, 16'h0000, 0, 0, 1, "rk.first",  0, 2'b00, 3'b000, 8'd0);
    cyc(16'hA012, 16'h0000, 0, 0, 1, "rk.next",   0, 2'b00, 3'b000, 8'd0);
    cyc(16'hE000, 16'h0000, 0, 0, 0, "", 0, 2'b00, 3'b000, 8'd0);
    cyc(16'hA010, 16'h0000, 0, 0, 1, "rk.entry",  1, 2'b01, 3'b100, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
